// File: rtl/frame_filter.sv
// Ethernet destination/ethertype filter: strips the 112-bit header from a beat stream
// and forwards the payload of accepted frames, with a programmable MAC table and counters.
module frame_filter #(
  parameter int          DW           = 2,
  parameter int          N_ENTRIES    = 4,
  parameter logic [47:0] RESET_MAC0   = 48'h69695A065491,
  parameter int          ACCEPT_BCAST = 1,
  parameter int          ETYPE_FILTER = 0,
  parameter logic [15:0] ETYPE        = 16'h0800,
  localparam int         AW           = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          axiiv,
  input  logic [DW-1:0] axiid,
  output logic          axiov,
  output logic [DW-1:0] axiod,
  input  logic          promisc,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [47:0]   cfg_mac,
  input  logic          cfg_en,
  output logic          frame_ok,
  output logic          frame_drop,
  output logic [15:0]   ok_count,
  output logic [15:0]   drop_count
);

  localparam int HDR_BEATS = 112 / DW;
  localparam int HW        = 112 - DW;
  localparam int CW        = $clog2(HDR_BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PASS,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hdr_q, hdr_d;
  logic [47:0]   mac_q [N_ENTRIES];
  logic [47:0]   mac_d [N_ENTRIES];
  logic [N_ENTRIES-1:0] en_q, en_d;
  logic          axiov_q, axiov_d;
  logic [DW-1:0] axiod_q, axiod_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_drop_q, frame_drop_d;
  logic [15:0]   ok_count_q, ok_count_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic [47:0]   dest;
  logic [15:0]   etype;
  logic          hit;
  logic          accept;
  logic          last_beat;

  // Only HDR_BEATS-1 beats are stored; the decision beat is taken straight from axiid,
  // so the full header is {hdr_q, axiid} during the decision cycle.
  assign dest      = hdr_q[HW-1 -: 48];
  assign etype     = {hdr_q[15-DW:0], axiid};
  assign last_beat = (cnt_q == CW'(HDR_BEATS - 1));

  always_comb begin
    hit = promisc || ((ACCEPT_BCAST != 0) && (dest == '1));
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (en_q[i] && (mac_q[i] == dest)) hit = 1'b1;
    end
    accept = hit && ((ETYPE_FILTER == 0) || (etype == ETYPE));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    frame_ok_d   = 1'b0;
    frame_drop_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (axiiv) begin
          hdr_d   = {hdr_q[HW-DW-1:0], axiid};
          cnt_d   = CW'(1);
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!axiiv) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          frame_drop_d = 1'b1;
        end else if (last_beat) begin
          state_d      = accept ? S_PASS : S_DROP;
          cnt_d        = '0;
          frame_ok_d   = accept;
          frame_drop_d = !accept;
        end else begin
          hdr_d = {hdr_q[HW-DW-1:0], axiid};
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PASS, S_DROP: begin
        if (!axiiv) state_d = S_IDLE;
      end
      default: state_d = S_DROP;
    endcase

    axiov_d      = (state_q == S_PASS) && axiiv;
    axiod_d      = axiov_d ? axiid : '0;

    ok_count_d   = ok_count_q;
    drop_count_d = drop_count_q;
    if (frame_ok_d && (ok_count_q != '1))     ok_count_d   = ok_count_q + 16'd1;
    if (frame_drop_d && (drop_count_q != '1)) drop_count_d = drop_count_q + 16'd1;
  end

  // Table writes land on the edge, so a decision in the same cycle sees the old entry.
  always_comb begin
    mac_d = mac_q;
    en_d  = en_q;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (cfg_we && (32'(cfg_addr) == i)) begin
        mac_d[i] = cfg_mac;
        en_d[i]  = cfg_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_DROP;
      cnt_q        <= '0;
      hdr_q        <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= '0;
      frame_ok_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      ok_count_q   <= '0;
      drop_count_q <= '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        mac_q[i] <= (i == 0) ? RESET_MAC0 : '0;
        en_q[i]  <= (i == 0);
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      frame_ok_q   <= frame_ok_d;
      frame_drop_q <= frame_drop_d;
      ok_count_q   <= ok_count_d;
      drop_count_q <= drop_count_d;
      mac_q        <= mac_d;
      en_q         <= en_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign frame_ok   = frame_ok_q;
  assign frame_drop = frame_drop_q;
  assign ok_count   = ok_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_frame_filter.sv
// Directed bench for frame_filter: one default instance and one with ethertype filtering,
// both fed the same dibit stream.
module tb_frame_filter;

  localparam logic [47:0] MAC0  = 48'h69695A065491;
  localparam logic [47:0] MAC_B = 48'h112233445566;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        promisc;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [47:0] cfg_mac;
  logic        cfg_en;

  logic        axiov, frame_ok, frame_drop;
  logic [1:0]  axiod;
  logic [15:0] ok_count, drop_count;
  logic        axiov2, frame_ok2, frame_drop2;
  logic [1:0]  axiod2;
  logic [15:0] ok_count2, drop_count2;

  int n_tests = 0;
  int n_fail  = 0;

  int ov_n, ov_first, data_err, ok_n, ok_iter, drop_n, drop_iter, ov_after_rst;
  int ov2_n, ok2_n, drop2_n;

  always #5 clk = ~clk;

  frame_filter #(.DW(2), .N_ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(axiov), .axiod(axiod),
    .promisc(promisc), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mac(cfg_mac),
    .cfg_en(cfg_en), .frame_ok(frame_ok), .frame_drop(frame_drop),
    .ok_count(ok_count), .drop_count(drop_count)
  );

  frame_filter #(.DW(2), .N_ENTRIES(4), .ETYPE_FILTER(1), .ETYPE(16'h0800)) dut_et (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(axiov2), .axiod(axiod2),
    .promisc(promisc), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mac(cfg_mac),
    .cfg_en(cfg_en), .frame_ok(frame_ok2), .frame_drop(frame_drop2),
    .ok_count(ok_count2), .drop_count(drop_count2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat i of the stream is driven at iteration i; outputs sampled at iteration i
  // reflect the edge that consumed beat i-1. runt>0 truncates the frame to runt beats.
  task automatic run_frame(input logic [47:0] dst, input logic [15:0] et,
                           input int npay, input int runt, input int rst_at);
    logic [111:0] hdr;
    logic [1:0]   exp_d;
    int           total;
    bit           rst_seen;
    hdr = {dst, 48'h0A0B0C0D0E0F, et};
    total = (runt > 0) ? runt : 56 + npay;
    ov_n = 0; ov_first = -1; data_err = 0; ok_n = 0; ok_iter = -1;
    drop_n = 0; drop_iter = -1; ov_after_rst = 0; ov2_n = 0; ok2_n = 0; drop2_n = 0;
    rst_seen = 1'b0;
    for (int i = 0; i <= total + 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (axiov) begin
          ov_n++;
          if (ov_first < 0) ov_first = i;
          if (rst_seen) ov_after_rst++;
          exp_d = 2'((i - 57) * 3 + 1);
          if (axiod !== exp_d) data_err++;
        end else if (axiod !== 2'b00) begin
          data_err++;
        end
        if (frame_ok)   begin ok_n++;   ok_iter = i;   end
        if (frame_drop) begin drop_n++; drop_iter = i; end
        if (axiov2) ov2_n++;
        if (!axiov2 && axiod2 !== 2'b00) data_err++;
        if (frame_ok2)   ok2_n++;
        if (frame_drop2) drop2_n++;
      end
      rst = (i == rst_at);
      if (i == rst_at) rst_seen = 1'b1;
      if (i < total) begin
        axiiv = 1'b1;
        axiid = (i < 56) ? hdr[111 - 2*i -: 2] : 2'((i - 56) * 3 + 1);
      end else begin
        axiiv = 1'b0;
        axiid = 2'b00;
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [47:0] mac, input logic en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_mac = mac; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; axiiv = 1'b0; axiid = 2'b00; promisc = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_mac = '0; cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_axiov", {63'd0, axiov}, 64'd0);
    check_eq("rst_axiod", {62'd0, axiod}, 64'd0);
    check_eq("rst_pulses", {62'd0, frame_ok, frame_drop}, 64'd0);
    check_eq("rst_ok_count", {48'd0, ok_count}, 64'd0);
    check_eq("rst_drop_count", {48'd0, drop_count}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Accepted frame to table entry 0
    run_frame(MAC0, 16'h0800, 20, 0, -1);
    check_eq("a_ov_len", ov_n, 20);
    check_eq("a_ov_first", ov_first, 57);
    check_eq("a_data", data_err, 0);
    check_eq("a_ok_pulses", ok_n, 1);
    check_eq("a_ok_timing", ok_iter, 56);
    check_eq("a_drop_pulses", drop_n, 0);
    check_eq("a_ok_count", {48'd0, ok_count}, 64'd1);
    check_eq("a_et_ov_len", ov2_n, 20);

    // Unknown destination dropped, then passed in promiscuous mode
    run_frame(MAC_B, 16'h0800, 8, 0, -1);
    check_eq("b_ov_len", ov_n, 0);
    check_eq("b_drop_pulses", drop_n, 1);
    check_eq("b_drop_timing", drop_iter, 56);
    check_eq("b_drop_count", {48'd0, drop_count}, 64'd1);
    promisc = 1'b1;
    run_frame(MAC_B, 16'h0800, 8, 0, -1);
    promisc = 1'b0;
    check_eq("p_ov_len", ov_n, 8);
    check_eq("p_data", data_err, 0);
    check_eq("p_ok_count", {48'd0, ok_count}, 64'd2);

    // Program entry 2, resend; then broadcast
    cfg_write(2'd2, MAC_B, 1'b1);
    run_frame(MAC_B, 16'h0800, 8, 0, -1);
    check_eq("t_ov_len", ov_n, 8);
    check_eq("t_ok_count", {48'd0, ok_count}, 64'd3);
    run_frame(BCAST, 16'h0800, 8, 0, -1);
    check_eq("bc_ov_len", ov_n, 8);
    check_eq("bc_ok_count", {48'd0, ok_count}, 64'd4);

    // Disabled entry no longer matches
    cfg_write(2'd2, MAC_B, 1'b0);
    run_frame(MAC_B, 16'h0800, 8, 0, -1);
    check_eq("dis_ov_len", ov_n, 0);
    check_eq("dis_drop_count", {48'd0, drop_count}, 64'd2);

    // 30-dibit runt
    run_frame(MAC0, 16'h0800, 0, 30, -1);
    check_eq("r_ov_len", ov_n, 0);
    check_eq("r_drop_pulses", drop_n, 1);
    check_eq("r_drop_timing", drop_iter, 31);
    check_eq("r_drop_count", {48'd0, drop_count}, 64'd3);

    // Ethertype filtering on the second instance
    run_frame(MAC0, 16'h0806, 8, 0, -1);
    check_eq("e1_et_ov_len", ov2_n, 0);
    check_eq("e1_et_drop", drop2_n, 1);
    check_eq("e1_plain_ov_len", ov_n, 8);
    run_frame(MAC0, 16'h0800, 8, 0, -1);
    check_eq("e2_et_ov_len", ov2_n, 8);
    check_eq("e2_et_ok", ok2_n, 1);
    check_eq("e2_ok_count", {48'd0, ok_count}, 64'd6);

    // Reset at dibit 60 of an accepted frame
    run_frame(MAC0, 16'h0800, 20, 0, 60);
    check_eq("x_ov_len", ov_n, 4);
    check_eq("x_ov_after_rst", ov_after_rst, 0);
    check_eq("x_ok_pulses", ok_n, 1);
    check_eq("x_drop_pulses", drop_n, 0);
    check_eq("x_ok_count", {48'd0, ok_count}, 64'd0);
    check_eq("x_drop_count", {48'd0, drop_count}, 64'd0);

    // Recovery after reset; the reset table entry 0 is still live
    run_frame(MAC0, 16'h0800, 12, 0, -1);
    check_eq("y_ov_len", ov_n, 12);
    check_eq("y_data", data_err, 0);
    check_eq("y_ok_count", {48'd0, ok_count}, 64'd1);
    check_eq("y_et_ok_count", {48'd0, ok_count2}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
